led_step_ctrl: RTL and testbench
================================

# led_step_ctrl

Step-pulse generator feeding the LED sequencer's state-advance enable. Each cycle of `step` advances the sequencer by one state. Two raw pushbuttons are synchronised and debounced. The block has two modes:
- AUTO: a periodic prescaler tick produces `step`.
- MANUAL: each debounced press of the step button produces `step`.

## Interface
- `TICK_CYCLES`, default 50_000_000: AUTO step period in clk cycles; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level change; must be ≥ 1.
- `HOLD_CYCLES`, default 50_000_000: hold time before auto-repeat starts (`LED_STEP_REPEAT_EN` only).
- `REPEAT_CYCLES`, default 12_500_000: auto-repeat period (`LED_STEP_REPEAT_EN` only); must be ≥ 2.
- `CNT_W`, default 32: width of all internal counters.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_mode` input 1: raw mode pushbutton, asynchronous, active-high.
- `btn_step` input 1: raw step pushbutton, asynchronous, active-high.
- `step` output 1: single-cycle advance pulse to the LED sequencer.
- `auto_mode` output 1: 1 = AUTO, 0 = MANUAL.

## Operation
- **Reset values:** `step`=0, `auto_mode`=1 (AUTO), all counters 0, synchroniser flops 0, debounced levels 0.
- **Per-button front end:**
  - 2-flop synchroniser.
  - Debounce counter increments each cycle the synced level differs from the debounced level and clears on any cycle they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A registered rising-edge detect on the debounced level gives a one-cycle `press`. Releases produce nothing.
- **Mode FSM:** states MODE_AUTO and MODE_MANUAL. A `press` on the mode button toggles the state; no other transitions exist.
- **AUTO:**
  - Prescaler counts 0..`TICK_CYCLES`-1 and wraps.
  - Terminal count registers `step`=1 on the next cycle.
  - Step-button presses are ignored.
- **MANUAL:**
  - Prescaler is held at 0.
  - A step-button `press` registers `step`=1 on the next cycle.
- **Mode entry:** entering either mode clears the prescaler. The first AUTO step comes exactly `TICK_CYCLES` cycles after the toggle.
- **Simultaneous events:**
  - Mode toggle in the same cycle as a prescaler terminal count: toggle wins, no step.
  - Mode toggle in the same cycle as a step `press`: toggle wins, press discarded.
  - Both buttons pressed together: only the mode toggle takes effect.
- **Pulse spacing:** `step` is never high in two consecutive cycles.
- **Reset mid-operation:** immediate return to reset values. A button held through reset is re-debounced after reset release and produces a `press` once accepted.

## Timing
- **Step-button latency:** the raw button is first sampled high at edge 0 and held stable. Pipeline is sync (2) + debounce (`DEBOUNCE_CYCLES`) + edge detect (1), and `step` is high during the cycle after edge `DEBOUNCE_CYCLES`+3.
- **Mode-button latency:** same pipeline, with `auto_mode` changing after edge `DEBOUNCE_CYCLES`+3.
- **Glitches:** raw glitches shorter than `DEBOUNCE_CYCLES` synced cycles produce no event.
- **AUTO steady state:** `step` pulses every exactly `TICK_CYCLES` cycles.

## Configuration
- **`LED_STEP_REPEAT_EN` defined:** in MANUAL, while the debounced step button stays high:
  - First step on the press, as normal.
  - Next step `HOLD_CYCLES` cycles after that press pulse.
  - Further steps every `REPEAT_CYCLES` cycles thereafter.
  - Release, mode toggle or reset clears the hold/repeat counter immediately.
- **`LED_STEP_REPEAT_EN` undefined:** exactly one step per press. The hold/repeat counter and the `HOLD_CYCLES`/`REPEAT_CYCLES` parameter uses are absent from the logic.

## Structure
- **Package `led_ctrl_pkg`:**
  - `mode_t` enum {MODE_AUTO, MODE_MANUAL}.
  - Default-value localparams for `TICK_CYCLES`, `DEBOUNCE_CYCLES`, `HOLD_CYCLES` and `REPEAT_CYCLES`.
  - Shared with the LED sequencer.
- **Sub-module `btn_debounce`:** synchroniser, debounce counter and rising-edge `press` output. Instantiated twice, once per button.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `TICK_CYCLES`=10, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5.
- **Reset:** assert rst mid-count -> `step`=0 and `auto_mode`=1 immediately; after release, first `step` 10 cycles later, then every 10 cycles.
- **Mode toggle:** clean `btn_mode` press -> `auto_mode` goes 0 after edge 7. While in MANUAL, no `step` for 50 cycles.
- **Manual step:** in MANUAL, `btn_step` high at edge 0 -> single `step` pulse during the cycle after edge 7; release -> no pulse.
- **Glitch rejection:** `btn_step` pulses of 1–3 cycles in MANUAL -> zero `step` pulses.
- **Simultaneous presses:** `btn_mode` and `btn_step` pressed on the same edge in MANUAL -> `auto_mode`=1, no `step`, next `step` 10 cycles after the toggle.
- **Auto-repeat** (`LED_STEP_REPEAT_EN`): hold `btn_step` for 40 cycles in MANUAL -> steps at press+0, +20, +25, +30, +35; release -> none further. With the macro undefined, the same stimulus -> exactly 1 step.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types and default timing for the LED sequencer and its step-pulse controller.
package led_ctrl_pkg;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_t;

  localparam int unsigned DEF_TICK_CYCLES     = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 12_500_000;
  localparam int unsigned DEF_CNT_W           = 32;

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton front end: 2-flop synchroniser, level debounce and a
// registered one-cycle press pulse on each accepted rising level.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] db_cnt;
  logic             level_prev;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop in the chain samples its pre-edge input value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      db_cnt     <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      press      <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      // Count consecutive disagreeing cycles; any agreement restarts the count.
      if (sync_q == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
      level_prev <= level;
      press      <= level & ~level_prev;
    end
  end

endmodule

// File: rtl/led_step_ctrl.sv
// Step-pulse generator for the LED sequencer: AUTO prescaler or MANUAL button steps.
// Optional hold-to-repeat in MANUAL is enabled by defining LED_STEP_REPEAT_EN.
module led_step_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode,
  input  logic btn_step,
  output logic step,
  output logic auto_mode
);

  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("led_step_ctrl: TICK_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("led_step_ctrl: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             step_q, step_d;
  logic             mode_press, step_press;
  logic             mode_level_unused;

`ifdef LED_STEP_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             step_level;
  logic             rpt_active_q, rpt_active_d;
  logic             rpt_hold_q, rpt_hold_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`else
  logic             step_level_unused;
`endif

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .level (mode_level_unused),
    .press (mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_step_db (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_step),
`ifdef LED_STEP_REPEAT_EN
    .level (step_level),
`else
    .level (step_level_unused),
`endif
    .press (step_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_AUTO;
      presc_q <= '0;
      step_q  <= 1'b0;
`ifdef LED_STEP_REPEAT_EN
      rpt_active_q <= 1'b0;
      rpt_hold_q   <= 1'b0;
      rpt_cnt_q    <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      step_q  <= step_d;
`ifdef LED_STEP_REPEAT_EN
      rpt_active_q <= rpt_active_d;
      rpt_hold_q   <= rpt_hold_d;
      rpt_cnt_q    <= rpt_cnt_d;
`endif
    end
  end

  // NOTE: every always_comb output is given a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    mode_d  = mode_q;
    presc_d = '0;
    step_d  = 1'b0;
`ifdef LED_STEP_REPEAT_EN
    rpt_active_d = 1'b0;
    rpt_hold_d   = 1'b0;
    rpt_cnt_d    = '0;
`endif
    // A mode toggle takes priority over any step source in the same cycle.
    unique case (mode_q)
      MODE_AUTO: begin
        if (mode_press) begin
          mode_d = MODE_MANUAL;
        end else if (presc_q == TICK_LAST) begin
          step_d = 1'b1;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
      end
      MODE_MANUAL: begin
        if (mode_press) begin
          mode_d = MODE_AUTO;
        end else if (step_press) begin
          step_d = 1'b1;
`ifdef LED_STEP_REPEAT_EN
          rpt_active_d = 1'b1;
          rpt_hold_d   = 1'b1;
`endif
        end
`ifdef LED_STEP_REPEAT_EN
        else if (rpt_active_q && step_level) begin
          // Hold phase waits HOLD_CYCLES after the press pulse, then repeats.
          rpt_active_d = 1'b1;
          if (rpt_cnt_q == (rpt_hold_q ? HOLD_LAST : REPEAT_LAST)) begin
            step_d = 1'b1;
          end else begin
            rpt_hold_d = rpt_hold_q;
            rpt_cnt_d  = rpt_cnt_q + CNT_W'(1);
          end
        end
`endif
      end
    endcase
  end

  assign step      = step_q;
  assign auto_mode = (mode_q == MODE_AUTO);

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with DEBOUNCE=4, TICK=10, HOLD=20, REPEAT=5.
module tb_led_step_ctrl;

  logic clk;
  logic rst;
  logic btn_mode;
  logic btn_step;
  logic step;
  logic auto_mode;

  int unsigned edge_cnt  = 0;
  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned step_q[$];

  led_step_ctrl #(
    .TICK_CYCLES     (10),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (5),
    .CNT_W           (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_step  (btn_step),
    .step      (step),
    .auto_mode (auto_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Log the edge number after which each step pulse is observed.
  always @(negedge clk) if (step === 1'b1) step_q.push_back(edge_cnt);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int unsigned e;
    rst = 1'b1; btn_mode = 1'b0; btn_step = 1'b0;
    tick(3);
    total_cnt++;
    if (step !== 1'b0) $display("FAIL reset_step: got %b want 0", step); else pass_cnt++;
    total_cnt++;
    if (auto_mode !== 1'b1) $display("FAIL reset_auto_mode: got %b want 1", auto_mode); else pass_cnt++;
    e = edge_cnt;
    step_q.delete();
    rst = 1'b0;
    tick(35);
    total_cnt++;
    if (step_q.size() != 3) $display("FAIL auto_count: got %0d want 3", step_q.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (i >= step_q.size()) $display("FAIL auto_step%0d: missing, want edge %0d", i, e + 10 * (i + 1));
      else if (step_q[i] != e + 10 * (i + 1))
        $display("FAIL auto_step%0d: got edge %0d want %0d", i, step_q[i], e + 10 * (i + 1));
      else pass_cnt++;
    end
    tick(5);
    total_cnt++;
    if (step !== 1'b1) $display("FAIL auto_step_e40: got %b want 1", step); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (step !== 1'b0) $display("FAIL midreset_step: got %b want 0", step); else pass_cnt++;
    total_cnt++;
    if (auto_mode !== 1'b1) $display("FAIL midreset_auto_mode: got %b want 1", auto_mode); else pass_cnt++;
    tick(2);
  endtask

  // Toggle lands on the same edge as the second prescaler terminal count.
  task automatic test_mode_toggle;
    int unsigned e;
    e = edge_cnt;
    step_q.delete();
    rst = 1'b0;
    tick(12);
    btn_mode = 1'b1;
    tick(7);
    total_cnt++;
    if (auto_mode !== 1'b1) $display("FAIL mode_before_edge7: got %b want 1", auto_mode); else pass_cnt++;
    tick(1);
    total_cnt++;
    if (auto_mode !== 1'b0) $display("FAIL mode_after_edge7: got %b want 0", auto_mode); else pass_cnt++;
    total_cnt++;
    if (step !== 1'b0) $display("FAIL toggle_vs_terminal: got %b want 0", step); else pass_cnt++;
    tick(1);
    btn_mode = 1'b0;
    tick(50);
    total_cnt++;
    if (step_q.size() != 1) $display("FAIL manual_quiet_count: got %0d want 1", step_q.size());
    else if (step_q[0] != e + 10) $display("FAIL manual_quiet_first: got edge %0d want %0d", step_q[0], e + 10);
    else pass_cnt++;
    total_cnt++;
    if (auto_mode !== 1'b0) $display("FAIL mode_release: got %b want 0", auto_mode); else pass_cnt++;
  endtask

  task automatic test_manual_step;
    int unsigned e;
    e = edge_cnt;
    step_q.delete();
    btn_step = 1'b1;
    tick(7);
    total_cnt++;
    if (step !== 1'b0) $display("FAIL manual_step_edge6: got %b want 0", step); else pass_cnt++;
    tick(1);
    total_cnt++;
    if (step !== 1'b1) $display("FAIL manual_step_edge7: got %b want 1", step); else pass_cnt++;
    tick(7);
    btn_step = 1'b0;
    tick(20);
    total_cnt++;
    if (step_q.size() != 1) $display("FAIL manual_step_count: got %0d want 1", step_q.size());
    else if (step_q[0] != e + 8) $display("FAIL manual_step_edge: got edge %0d want %0d", step_q[0], e + 8);
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    int unsigned e;
    step_q.delete();
    for (int w = 1; w <= 3; w++) begin
      btn_step = 1'b1;
      tick(w);
      btn_step = 1'b0;
      tick(8);
    end
    total_cnt++;
    if (step_q.size() != 0) $display("FAIL glitch_count: got %0d want 0", step_q.size()); else pass_cnt++;
    // A pulse of exactly DEBOUNCE_CYCLES is accepted.
    e = edge_cnt;
    btn_step = 1'b1;
    tick(4);
    btn_step = 1'b0;
    tick(15);
    total_cnt++;
    if (step_q.size() != 1) $display("FAIL min_pulse_count: got %0d want 1", step_q.size());
    else if (step_q[0] != e + 8) $display("FAIL min_pulse_edge: got edge %0d want %0d", step_q[0], e + 8);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    int unsigned e;
    e = edge_cnt;
    step_q.delete();
    btn_mode = 1'b1;
    btn_step = 1'b1;
    tick(8);
    total_cnt++;
    if (auto_mode !== 1'b1) $display("FAIL simul_mode: got %b want 1", auto_mode); else pass_cnt++;
    total_cnt++;
    if (step !== 1'b0) $display("FAIL simul_step: got %b want 0", step); else pass_cnt++;
    tick(2);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    tick(20);
    total_cnt++;
    if (step_q.size() != 2) $display("FAIL simul_count: got %0d want 2", step_q.size());
    else if (step_q[0] != e + 18 || step_q[1] != e + 28)
      $display("FAIL simul_edges: got %0d,%0d want %0d,%0d", step_q[0], step_q[1], e + 18, e + 28);
    else pass_cnt++;
    // Back to MANUAL for the hold test.
    btn_mode = 1'b1;
    tick(10);
    btn_mode = 1'b0;
    tick(10);
    total_cnt++;
    if (auto_mode !== 1'b0) $display("FAIL reenter_manual: got %b want 0", auto_mode); else pass_cnt++;
  endtask

  task automatic test_repeat;
    int unsigned e;
    int unsigned exp_q[$];
    e = edge_cnt;
    step_q.delete();
    btn_step = 1'b1;
    tick(40);
    btn_step = 1'b0;
    tick(30);
    exp_q.push_back(e + 8);
`ifdef LED_STEP_REPEAT_EN
    exp_q.push_back(e + 28);
    exp_q.push_back(e + 33);
    exp_q.push_back(e + 38);
    exp_q.push_back(e + 43);
`endif
    total_cnt++;
    if (step_q.size() != exp_q.size())
      $display("FAIL hold_count: got %0d want %0d", step_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (i >= step_q.size()) $display("FAIL hold_step%0d: missing, want edge %0d", i, exp_q[i]);
      else if (step_q[i] != exp_q[i])
        $display("FAIL hold_step%0d: got edge %0d want %0d", i, step_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  // Mode button held through reset is re-debounced and toggles once accepted.
  task automatic test_reset_held;
    int unsigned e;
    btn_mode = 1'b1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (auto_mode !== 1'b1) $display("FAIL reset_from_manual: got %b want 1", auto_mode); else pass_cnt++;
    tick(3);
    e = edge_cnt;
    rst = 1'b0;
    tick(7);
    total_cnt++;
    if (auto_mode !== 1'b1) $display("FAIL held_before_edge7: got %b want 1", auto_mode); else pass_cnt++;
    tick(1);
    total_cnt++;
    if (auto_mode !== 1'b0) $display("FAIL held_after_edge7: got %b want 0 (edge %0d)", auto_mode, e + 8);
    else pass_cnt++;
    btn_mode = 1'b0;
    tick(15);
  endtask

  initial begin
    test_reset();
    test_mode_toggle();
    test_manual_step();
    test_glitch();
    test_simultaneous();
    test_repeat();
    test_reset_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
